// File: rtl/sfifo_pkg.sv
// sfifo_pkg: shared definitions for the sfifo_param slice.
//   clog2()              constant-evaluable ceiling log2 used to derive ADDR_WIDTH
//   SFIFO_RD_DAT_RST     fill bit replicated across rd_dat for its reset value
//   sfifo_lvl_t          pointer/level type for the default 16-entry build;
//                        modules declare their own ptr_t of ADDR_WIDTH+1 bits
package sfifo_pkg;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < value) r = r + 1;
    return r;
  endfunction

  localparam logic SFIFO_RD_DAT_RST = 1'b0;

  localparam int unsigned SFIFO_DEF_DEPTH = 16;
  typedef logic [clog2(SFIFO_DEF_DEPTH):0] sfifo_lvl_t;

endpackage

// File: rtl/sfifo_param_if.sv
// sfifo_param_if: client-side bundle of the single-clock FIFO.
//   master: drives clr, wr, wr_dat, rd, cfg_almost_full, cfg_almost_empty
//   slave : drives rd_dat, rd_dat_valid, full, empty, almost_full,
//           almost_empty, level, overflow, underflow
interface sfifo_param_if #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = sfifo_pkg::clog2(DEPTH)
);
  logic                  clr;
  logic                  wr;
  logic [DATA_WIDTH-1:0] wr_dat;
  logic                  rd;
  logic [DATA_WIDTH-1:0] rd_dat;
  logic                  rd_dat_valid;
  logic [ADDR_WIDTH:0]   cfg_almost_full;
  logic [ADDR_WIDTH:0]   cfg_almost_empty;
  logic                  full;
  logic                  empty;
  logic                  almost_full;
  logic                  almost_empty;
  logic [ADDR_WIDTH:0]   level;
  logic                  overflow;
  logic                  underflow;

  modport master (
    output clr, wr, wr_dat, rd, cfg_almost_full, cfg_almost_empty,
    input  rd_dat, rd_dat_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );

  modport slave (
    input  clr, wr, wr_dat, rd, cfg_almost_full, cfg_almost_empty,
    output rd_dat, rd_dat_valid, full, empty, almost_full, almost_empty,
           level, overflow, underflow
  );
endinterface

// File: rtl/sfifo_ram.sv
// sfifo_ram: simple dual-port storage, DATA_WIDTH x DEPTH, no reset.
//   clk          write/read clock
//   we/waddr/wdata  synchronous write port
//   re/raddr/rdata  read port: registered (enabled by re) by default,
//                   combinational when SFIFO_FWFT_EN is defined (re unused)
module sfifo_ram #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

`ifdef SFIFO_FWFT_EN
  assign rdata = mem[raddr];
`else
  // Holds its last value when no read is accepted.
  always_ff @(posedge clk) begin
    if (re) rdata <= mem[raddr];
  end
`endif

endmodule

// File: rtl/sfifo_param.sv
// sfifo_param: parametrised single-clock FIFO with level, programmable
// almost-full/almost-empty thresholds, synchronous flush and sticky
// overflow/underflow flags.
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    sfifo_param_if.slave: clr, wr/wr_dat, rd/rd_dat/rd_dat_valid,
//          cfg_almost_full/cfg_almost_empty, full, empty, almost_full,
//          almost_empty, level, overflow, underflow
// Build option: define SFIFO_FWFT_EN for first-word-fall-through output.
module sfifo_param
  import sfifo_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_WIDTH = clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst_n,
  sfifo_param_if.slave  bus
);

  typedef logic [ADDR_WIDTH:0] ptr_t;

  localparam ptr_t DEPTH_P = ptr_t'(DEPTH);

  ptr_t                  wr_ptr;
  ptr_t                  rd_ptr;
  ptr_t                  level;
  logic                  full_i;
  logic                  empty_i;
  logic                  wr_acc;
  logic                  rd_acc;
  logic                  overflow_q;
  logic                  underflow_q;
  logic [DATA_WIDTH-1:0] ram_q;

  // Modulo subtraction; the wrap bit disambiguates full from empty.
  assign level   = wr_ptr - rd_ptr;
  assign full_i  = (level == DEPTH_P);
  assign empty_i = (level == '0);

  // clr takes priority: nothing is accepted in a flush cycle.
  assign wr_acc = bus.wr && !full_i  && !bus.clr;
  assign rd_acc = bus.rd && !empty_i && !bus.clr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else if (bus.clr) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (wr_acc)           wr_ptr      <= wr_ptr + 1'b1;
      if (rd_acc)           rd_ptr      <= rd_ptr + 1'b1;
      if (bus.wr && full_i)  overflow_q  <= 1'b1;
      if (bus.rd && empty_i) underflow_q <= 1'b1;
    end
  end

  sfifo_ram #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr[ADDR_WIDTH-1:0]),
    .wdata (bus.wr_dat),
    .re    (rd_acc),
    .raddr (rd_ptr[ADDR_WIDTH-1:0]),
    .rdata (ram_q)
  );

`ifdef SFIFO_FWFT_EN
  // Head is visible whenever the FIFO holds data; masked to the reset
  // value while empty so reset never exposes stale memory.
  assign bus.rd_dat       = empty_i ? {DATA_WIDTH{SFIFO_RD_DAT_RST}} : ram_q;
  assign bus.rd_dat_valid = !empty_i;
`else
  logic rd_vld_q;
  logic rd_seen_q;

  // The RAM read register has no reset; rd_seen_q masks it to the reset
  // value until the first accepted read after reset (clr leaves it alone,
  // so rd_dat keeps holding its last value across a flush).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_vld_q  <= 1'b0;
      rd_seen_q <= 1'b0;
    end else begin
      rd_vld_q <= rd_acc;
      if (rd_acc) rd_seen_q <= 1'b1;
    end
  end

  assign bus.rd_dat       = rd_seen_q ? ram_q : {DATA_WIDTH{SFIFO_RD_DAT_RST}};
  assign bus.rd_dat_valid = rd_vld_q;
`endif

  assign bus.level        = level;
  assign bus.full         = full_i;
  assign bus.empty        = empty_i;
  assign bus.almost_full  = (level >= bus.cfg_almost_full);
  assign bus.almost_empty = (level <= bus.cfg_almost_empty);
  assign bus.overflow     = overflow_q;
  assign bus.underflow    = underflow_q;

endmodule

// File: tb/tb_sfifo_param.sv
// tb_sfifo_param: directed self-checking bench for sfifo_param
// (DATA_WIDTH=8, DEPTH=16). Expected values are hand-derived constants.
// Build option: SFIFO_FWFT_EN selects the first-word-fall-through checks.
module tb_sfifo_param;

  logic clk;
  logic rst_n;

  int unsigned n_cmp;
  int unsigned n_err;

  sfifo_param_if #(.DATA_WIDTH(8), .DEPTH(16)) bus ();

  sfifo_param #(.DATA_WIDTH(8), .DEPTH(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One cycle of traffic; with c set, checks that the popped word equals e.
  task automatic xfer(input logic w, input logic [7:0] d, input logic r,
                      input logic c, input logic [7:0] e);
    bus.wr     = w;
    bus.wr_dat = d;
    bus.rd     = r;
`ifdef SFIFO_FWFT_EN
    if (c) begin
      chk("head_dat", 32'(bus.rd_dat), 32'(e));
      chk("head_vld", 32'(bus.rd_dat_valid), 32'd1);
    end
    tick();
`else
    tick();
    if (c) begin
      chk("rd_dat", 32'(bus.rd_dat), 32'(e));
      chk("rd_vld", 32'(bus.rd_dat_valid), 32'd1);
    end
`endif
    bus.wr = 1'b0;
    bus.rd = 1'b0;
  endtask

  task automatic chk_reset_values();
    chk("rst_rd_dat", 32'(bus.rd_dat), 32'h0);
    chk("rst_vld",    32'(bus.rd_dat_valid), 32'd0);
    chk("rst_level",  32'(bus.level), 32'd0);
    chk("rst_full",   32'(bus.full), 32'd0);
    chk("rst_empty",  32'(bus.empty), 32'd1);
    chk("rst_ovf",    32'(bus.overflow), 32'd0);
    chk("rst_udf",    32'(bus.underflow), 32'd0);
    chk("rst_ae",     32'(bus.almost_empty), 32'd1);
    chk("rst_af",     32'(bus.almost_full), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish within time limit");
    $fatal(1);
  end

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n                = 1'b0;
    bus.clr              = 1'b0;
    bus.wr               = 1'b0;
    bus.wr_dat           = '0;
    bus.rd               = 1'b0;
    bus.cfg_almost_full  = '0;
    bus.cfg_almost_empty = 5'd3;

    // Reset state; almost_full follows cfg combinationally
    #3;
    chk("af_cfg0", 32'(bus.almost_full), 32'd1);
    bus.cfg_almost_full = 5'd12;
    #1;
    chk_reset_values();
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fill 0x00..0x0F with threshold tracking
    for (int i = 0; i < 16; i++) begin
      xfer(1'b1, 8'(i), 1'b0, 1'b0, 8'h00);
      chk("fill_level", 32'(bus.level), 32'(i + 1));
      chk("fill_af",    32'(bus.almost_full), 32'((i + 1) >= 12));
      chk("fill_ae",    32'(bus.almost_empty), 32'((i + 1) <= 3));
      if (i == 0) chk("first_not_empty", 32'(bus.empty), 32'd0);
    end
    chk("full", 32'(bus.full), 32'd1);
    chk("full_level", 32'(bus.level), 32'd16);

    // Write while full: dropped word, sticky overflow
    xfer(1'b1, 8'hEE, 1'b0, 1'b0, 8'h00);
    chk("ovf_level", 32'(bus.level), 32'd16);
    chk("ovf_set",   32'(bus.overflow), 32'd1);
    tick();
    chk("ovf_sticky", 32'(bus.overflow), 32'd1);

    // Drain in order; 0xEE must not appear
    for (int i = 0; i < 16; i++) xfer(1'b0, 8'h00, 1'b1, 1'b1, 8'(i));
    tick();
`ifndef SFIFO_FWFT_EN
    chk("vld_one_cycle", 32'(bus.rd_dat_valid), 32'd0);
`endif
    chk("drained_empty", 32'(bus.empty), 32'd1);
    chk("drained_level", 32'(bus.level), 32'd0);

    // Read while empty
    xfer(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("udf_set", 32'(bus.underflow), 32'd1);
    chk("udf_vld", 32'(bus.rd_dat_valid), 32'd0);
    chk("ovf_still", 32'(bus.overflow), 32'd1);

    // clr clears error flags
    bus.clr = 1'b1;
    tick();
    bus.clr = 1'b0;
    chk("clr_ovf",   32'(bus.overflow), 32'd0);
    chk("clr_udf",   32'(bus.underflow), 32'd0);
    chk("clr_level", 32'(bus.level), 32'd0);

    // Level 5, then 100 cycles of wr+rd across pointer wrap
    for (int i = 0; i < 5; i++) xfer(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 8'h00);
    chk("lvl5", 32'(bus.level), 32'd5);
    for (int k = 0; k < 100; k++) begin
      xfer(1'b1, 8'(8'h45 + k), 1'b1, 1'b1, 8'(8'h40 + k));
      chk("stream_level", 32'(bus.level), 32'd5);
    end
    for (int j = 0; j < 5; j++) xfer(1'b0, 8'h00, 1'b1, 1'b1, 8'(8'hA4 + j));
    chk("stream_empty", 32'(bus.empty), 32'd1);
    tick();

    // wr+rd at level 0: only the write lands
    xfer(1'b1, 8'h77, 1'b1, 1'b0, 8'h00);
    chk("wrrd0_level", 32'(bus.level), 32'd1);
    chk("wrrd0_udf",   32'(bus.underflow), 32'd1);
    chk("wrrd0_vld",   32'(bus.rd_dat_valid), 32'd0);
    xfer(1'b0, 8'h00, 1'b1, 1'b1, 8'h77);

    // Flush at level 9 with wr and rd also asserted
    for (int i = 0; i < 9; i++) xfer(1'b1, 8'(8'h90 + i), 1'b0, 1'b0, 8'h00);
    chk("lvl9", 32'(bus.level), 32'd9);
    bus.clr = 1'b1;
    xfer(1'b1, 8'h55, 1'b1, 1'b0, 8'h00);
    bus.clr = 1'b0;
    chk("flush_level", 32'(bus.level), 32'd0);
    chk("flush_empty", 32'(bus.empty), 32'd1);
    chk("flush_vld",   32'(bus.rd_dat_valid), 32'd0);
    chk("flush_udf",   32'(bus.underflow), 32'd0);

    // Asynchronous reset mid-stream
    for (int i = 0; i < 3; i++) xfer(1'b1, 8'(8'h31 + i), 1'b0, 1'b0, 8'h00);
    xfer(1'b0, 8'h00, 1'b1, 1'b1, 8'h31);
    bus.wr     = 1'b1;
    bus.wr_dat = 8'h34;
    bus.rd     = 1'b1;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk_reset_values();
    bus.wr = 1'b0;
    bus.rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post_rst_level", 32'(bus.level), 32'd0);

`ifdef SFIFO_FWFT_EN
    // Fall-through: head visible the cycle after the write, no rd needed
    xfer(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
    chk("fwft_dat", 32'(bus.rd_dat), 32'hA5);
    chk("fwft_vld", 32'(bus.rd_dat_valid), 32'd1);
    xfer(1'b0, 8'h00, 1'b1, 1'b0, 8'h00);
    chk("fwft_pop_empty", 32'(bus.empty), 32'd1);
    chk("fwft_pop_vld",   32'(bus.rd_dat_valid), 32'd0);
`else
    // Registered read: word appears exactly one cycle after rd
    xfer(1'b1, 8'hA5, 1'b0, 1'b0, 8'h00);
    chk("std_no_rd_vld", 32'(bus.rd_dat_valid), 32'd0);
    xfer(1'b0, 8'h00, 1'b1, 1'b1, 8'hA5);
    chk("std_pop_empty", 32'(bus.empty), 32'd1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
